// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner
// encoding and the starvation counter width.
package mem_arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants taken while fetch was waiting; saturates at
// LIMIT and flags when fetch must be given the port.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    clr,
    output logic [STARVE_CNT_W-1:0] count,
    output logic                    at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    assign at_limit = (count >= LIMIT_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory command port between instruction fetch and data access.
// Data normally wins; fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        dbg_state_o
);

    arb_state_e state, state_nxt;
    owner_e     owner_q, owner_nxt;

    logic                    cnt_inc;
    logic                    cnt_clr;
    logic                    at_limit;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    pick_fetch;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk_i),
        .rst      (rst_i),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .count    (starve_cnt),
        .at_limit (at_limit)
    );

    // Handshake: a requester holds req and payload stable until its one-cycle
    // ack; the memory takes the command on mem_req_o & mem_gnt_i and answers
    // with a single mem_rvalid_i pulse no earlier than the next cycle.
    assign pick_fetch = if_req_i & (~d_req_i | at_limit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            owner_q <= OWN_FETCH;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner_q;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_ack_o    = 1'b0;
        d_ack_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_nxt = ST_ISSUE;
                    owner_nxt = pick_fetch ? OWN_FETCH : OWN_DATA;
                    // Only a data grant taken over a waiting fetch ages the counter.
                    if (pick_fetch || !if_req_i) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                mem_req_o = 1'b1;
                if (owner_q == OWN_DATA) begin
                    mem_we_o    = d_we_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                end else begin
                    mem_addr_o  = if_addr_i;
                end
                if (mem_gnt_i) begin
                    state_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_rvalid_i) begin
                    state_nxt = ST_IDLE;
                    if (owner_q == OWN_DATA) begin
                        d_ack_o  = 1'b1;
                    end else begin
                        if_ack_o = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;
    assign if_stall_o  = if_req_i & ~if_ack_o;
    assign d_stall_o   = d_req_i & ~d_ack_o;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation relief,
// grant back-pressure, stray responses and reset abandonment.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [ADDR_W+DATA_W:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_ack_o     (if_ack),
        .if_rdata_o   (if_rdata),
        .if_stall_o   (if_stall),
        .d_req_i      (d_req),
        .d_we_i       (d_we),
        .d_addr_i     (d_addr),
        .d_wdata_i    (d_wdata),
        .d_ack_o      (d_ack),
        .d_rdata_o    (d_rdata),
        .d_stall_o    (d_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Serves one transaction from IDLE: gnt after gnt_wait stalled ISSUE cycles,
    // rvalid after resp_wait idle WAIT_RESP cycles.
    task automatic run_txn(input string tag, input bit data_owner, input int gnt_wait,
                           input int resp_wait, input logic [DATA_W-1:0] rdata,
                           input logic [3:0] exp_cnt, input bit drop);
        logic [ADDR_W+DATA_W:0] cmd;
        logic [ADDR_W+DATA_W:0] exp_cmd;
        logic [1:0]             exp_ack;
        bit                     last;
        if (data_owner) exp_cmd = {d_we, d_addr, d_wdata};
        else            exp_cmd = {1'b0, if_addr, {DATA_W{1'b0}}};
        exp_q.push_back(exp_cmd);

        @(negedge clk);
        check({tag, "/idle_state"}, 64'(dbg_state), 64'(ST_IDLE));
        check({tag, "/idle_mem_req"}, 64'(mem_req), 64'd0);
        tick;
        if (drop) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end

        for (int i = 0; i <= gnt_wait; i++) begin
            mem_gnt    = (i == gnt_wait);
            mem_rvalid = (i == 2);
            @(negedge clk);
            cmd = {mem_we, mem_addr, mem_wdata};
            check({tag, "/issue_state"}, 64'(dbg_state), 64'(ST_ISSUE));
            check({tag, "/issue_mem_req"}, 64'(mem_req), 64'd1);
            check({tag, "/issue_addr"}, 64'(cmd[ADDR_W+DATA_W-1:DATA_W]),
                  64'(exp_q[0][ADDR_W+DATA_W-1:DATA_W]));
            check({tag, "/issue_we_wdata"}, 64'({cmd[ADDR_W+DATA_W], cmd[DATA_W-1:0]}),
                  64'({exp_q[0][ADDR_W+DATA_W], exp_q[0][DATA_W-1:0]}));
            check({tag, "/issue_acks"}, 64'({if_ack, d_ack}), 64'd0);
            check({tag, "/issue_stalls"}, 64'({if_stall, d_stall}), 64'({if_req, d_req}));
            if (i == 0) check({tag, "/starve_cnt"}, 64'(dut.u_starve.count), 64'(exp_cnt));
            if (i == gnt_wait) void'(exp_q.pop_front());
            tick;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end

        for (int j = 0; j <= resp_wait; j++) begin
            last       = (j == resp_wait);
            mem_rvalid = last;
            mem_rdata  = last ? rdata : DATA_W'(32'h0BAD_0000 + j);
            exp_ack    = !last ? 2'b00 : (data_owner ? 2'b01 : 2'b10);
            @(negedge clk);
            check({tag, "/wait_state"}, 64'(dbg_state), 64'(ST_WAIT_RESP));
            check({tag, "/wait_mem_req"}, 64'(mem_req), 64'd0);
            check({tag, "/acks"}, 64'({if_ack, d_ack}), 64'(exp_ack));
            check({tag, "/stalls"}, 64'({if_stall, d_stall}),
                  64'({if_req & ~exp_ack[1], d_req & ~exp_ack[0]}));
            if (last) check({tag, "/rdata"}, 64'(data_owner ? d_rdata : if_rdata), 64'(rdata));
            tick;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick;
        tick;
        @(negedge clk);
        check("rst/state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst/mem_cmd", 64'({mem_req, mem_we}), 64'd0);
        check("rst/mem_addr", 64'(mem_addr), 64'd0);
        check("rst/mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst/acks", 64'({if_ack, d_ack}), 64'd0);
        check("rst/starve_cnt", 64'(dut.u_starve.count), 64'd0);
        check("rst/owner", 64'(dut.owner_q), 64'(OWN_FETCH));
        tick;
        rst = 1'b0;

        // Single fetch: ack in the third cycle after the request is seen.
        if_addr = 32'h10; if_req = 1'b1;
        run_txn("fetch1", 1'b0, 0, 0, 32'hDEAD_BEEF, 4'd0, 1'b0);
        if_req = 1'b0;

        // Simultaneous requests: data write goes first, then fetch.
        d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5; d_req = 1'b1; if_req = 1'b1;
        run_txn("both_data", 1'b1, 0, 0, 32'h0000_1111, 4'd1, 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        run_txn("both_fetch", 1'b0, 0, 1, 32'hCAFE_0001, 4'd0, 1'b0);
        if_req = 1'b0;

        // Fetch held, data back-to-back: four data grants, then fetch.
        if_addr = 32'h40; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            d_addr = 32'h100 + 32'(4 * k);
            run_txn("starve_data", 1'b1, 0, 0, 32'h1000 + 32'(k), 4'(k + 1), 1'b0);
        end
        run_txn("starve_fetch", 1'b0, 0, 0, 32'h2000, 4'd0, 1'b0);
        if_req = 1'b0;
        run_txn("after_starve", 1'b1, 0, 0, 32'h3000, 4'd0, 1'b0);
        d_req = 1'b0;

        // Grant held off five cycles, with a stray rvalid during ISSUE.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hA5A5;
        run_txn("gnt_wait", 1'b1, 5, 2, 32'h0, 4'd0, 1'b0);
        d_req = 1'b0; d_we = 1'b0;

        // Requester drops out while owning; ack still pulses.
        if_addr = 32'h80; if_req = 1'b1;
        run_txn("drop", 1'b0, 1, 0, 32'h77, 4'd0, 1'b1);

        // Reset during WAIT_RESP abandons the transaction.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        tick;
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_mid/pre_state", 64'(dbg_state), 64'(ST_WAIT_RESP));
        tick;
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("rst_mid/state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_mid/mem_req", 64'(mem_req), 64'd0);
        tick;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("stray_rvalid/acks", 64'({if_ack, d_ack}), 64'd0);
        check("stray_rvalid/mem_req", 64'(mem_req), 64'd0);
        tick;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rvalid/state", 64'(dbg_state), 64'(ST_IDLE));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
